kernel_bc_write_back_start_consumer: RTL and testbench

//  Read-side controller for the write_back start-token FIFO, the consumer of kernel_bc_start_for_write_back59_U0.

---
 rtl/kernel_bc_dataflow_pkg.sv | 11 +
 rtl/kernel_bc_write_back_start_consumer.sv | 97 +++++++++
 tb/tb_kernel_bc_write_back_start_consumer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_bc_dataflow_pkg.sv
// Shared state encoding for the kernel_bc dataflow start-token consumers.
package kernel_bc_dataflow_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } df_state_t;

endpackage

// File: rtl/kernel_bc_write_back_start_consumer.sv
// Pops one start token, runs the write_back core through ap_start/ap_ready/ap_done,
// then pushes the token to the done FIFO and releases the core with ap_continue.
module kernel_bc_write_back_start_consumer
  import kernel_bc_dataflow_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ITER_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  start_empty_n,
  input  logic [DATA_WIDTH-1:0] start_dout,
  output logic                  start_read,
  output logic                  start_read_ce,
  output logic                  core_start,
  input  logic                  core_ready,
  input  logic                  core_done,
  output logic                  core_continue,
  input  logic                  done_full_n,
  output logic                  done_write,
  output logic [DATA_WIDTH-1:0] done_din,
  output logic                  idle,
  output logic [ITER_W-1:0]     iter_cnt,
  output logic                  proto_err,
  output logic [1:0]            dbg_state
);

  // Handshakes: a FIFO transfer happens in the cycle where the strobe
  // (start_read / done_write) and the FIFO flag (empty_n / full_n) are both
  // high; the core is launched while core_start is high and accepted on the
  // first cycle with core_ready high.

  df_state_t               r_state;
  df_state_t               w_next;
  logic [DATA_WIDTH-1:0]   r_tok;
  logic [ITER_W-1:0]       r_iter;
  logic                    r_err;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_err;

  always_comb begin
    w_next        = r_state;
    w_pop         = 1'b0;
    w_push        = 1'b0;
    start_read    = 1'b0;
    done_write    = 1'b0;
    core_continue = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop      = enable & start_empty_n;
        start_read = w_pop;
        if (w_pop) w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (core_ready) w_next = core_done ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (core_done) w_next = S_DONE;
      end
      S_DONE: begin
        w_push        = done_full_n;
        done_write    = done_full_n;
        core_continue = done_full_n;
        if (done_full_n) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A done seen before launch, or without the matching ready, is flagged but never acted on.
  assign w_err = core_done & ((r_state == S_IDLE) | ((r_state == S_LAUNCH) & ~core_ready));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tok   <= '0;
      r_iter  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop)  r_tok  <= start_dout;
      if (w_push) r_iter <= r_iter + ITER_W'(1);
      if (w_err)  r_err  <= 1'b1;
    end
  end

  assign start_read_ce = 1'b1;
  assign core_start    = (r_state == S_LAUNCH);
  assign idle          = (r_state == S_IDLE);
  assign done_din      = r_tok;
  assign iter_cnt      = r_iter;
  assign proto_err     = r_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_kernel_bc_write_back_start_consumer.sv
// Directed bench for the write_back start-token consumer: a vector table for the
// first iteration, then hand-written sequences for stalls, enable, reset and wrap.
module tb_kernel_bc_write_back_start_consumer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start_empty_n;
  logic [0:0]  start_dout;
  logic        core_ready;
  logic        core_done;
  logic        done_full_n;

  logic        start_read, start_read_ce, core_start, core_continue, done_write;
  logic [0:0]  done_din;
  logic        idle, proto_err;
  logic [15:0] iter_cnt;
  logic [1:0]  dbg_state;

  logic        b_start_read, b_start_read_ce, b_core_start, b_core_continue, b_done_write;
  logic [0:0]  b_done_din;
  logic        b_idle, b_proto_err;
  logic [1:0]  b_iter_cnt;
  logic [1:0]  b_dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_iter = 0;
  int cyc = 0;
  int last_pop = -1;
  int in_flight = 0;

  always #5 clk = ~clk;

  kernel_bc_write_back_start_consumer #(.DATA_WIDTH(1), .ITER_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start_empty_n(start_empty_n),
    .start_dout(start_dout), .start_read(start_read), .start_read_ce(start_read_ce),
    .core_start(core_start), .core_ready(core_ready), .core_done(core_done),
    .core_continue(core_continue), .done_full_n(done_full_n), .done_write(done_write),
    .done_din(done_din), .idle(idle), .iter_cnt(iter_cnt), .proto_err(proto_err),
    .dbg_state(dbg_state)
  );

  kernel_bc_write_back_start_consumer #(.DATA_WIDTH(1), .ITER_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .enable(enable), .start_empty_n(start_empty_n),
    .start_dout(start_dout), .start_read(b_start_read), .start_read_ce(b_start_read_ce),
    .core_start(b_core_start), .core_ready(core_ready), .core_done(core_done),
    .core_continue(b_core_continue), .done_full_n(done_full_n), .done_write(b_done_write),
    .done_din(b_done_din), .idle(b_idle), .iter_cnt(b_iter_cnt), .proto_err(b_proto_err),
    .dbg_state(b_dbg_state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pop spacing and single-token-in-flight monitor.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      in_flight = 0;
      last_pop  = -1;
    end else begin
      if (start_read) begin
        chk("in_flight_at_pop", in_flight, 0);
        if (last_pop >= 0) chk("pop_spacing_ge4", (cyc - last_pop) >= 4, 1);
        last_pop = cyc;
        in_flight++;
      end
      if (done_write) in_flight--;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full iteration: ready/done arrive one cycle after core_start is seen,
  // then the done FIFO is held full for 'stall' cycles.
  task automatic drive_iter(input logic tok, input int stall, input logic more);
    enable = 1'b1; start_empty_n = 1'b1; start_dout = tok;
    core_ready = 1'b0; core_done = 1'b0; done_full_n = 1'b1;
    #1;
    chk("it_start_read", start_read, 1);
    chk("it_idle", idle, 1);
    step();
    start_empty_n = more;
    #1;
    chk("it_core_start_a", core_start, 1);
    chk("it_no_pop_launch", start_read, 0);
    step();
    core_ready = 1'b1; core_done = 1'b1;
    #1;
    chk("it_core_start_b", core_start, 1);
    step();
    core_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      done_full_n = 1'b0;
      #1;
      chk("stall_done_write", done_write, 0);
      chk("stall_continue", core_continue, 0);
      chk("stall_state", dbg_state, 2'd3);
      step();
    end
    done_full_n = 1'b1;
    #1;
    chk("it_done_write", done_write, 1);
    chk("it_continue", core_continue, 1);
    chk("it_done_din", done_din, tok);
    step();
    core_done = 1'b0;
    exp_iter++;
    #1;
    chk("it_iter_cnt", iter_cnt, exp_iter & 32'hffff);
    chk("it_back_idle", idle, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; start_empty_n = 1'b0; start_dout = 1'b0;
    core_ready = 1'b0; core_done = 1'b0; done_full_n = 1'b1;
    step();
    step();
    exp_iter = 0;
    reset = 1'b0;
  endtask

  typedef struct {
    logic       en, empty_n, dout, ready, done, full_n;
    logic       e_sr, e_cs, e_dw, e_cont, e_idle, e_din;
    logic [1:0] e_state;
    logic [15:0] e_iter;
  } vec_t;

  vec_t vecs [7];

  initial begin
    //            en e  d  rd dn fn | sr cs dw ct id di st  iter
    vecs[0] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 2'd0, 16'd0};
    vecs[1] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 2'd1, 16'd0};
    vecs[2] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd2, 16'd0};
    vecs[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd2, 16'd0};
    vecs[4] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd2, 16'd0};
    vecs[5] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 2'd3, 16'd0};
    vecs[6] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 2'd0, 16'd1};

    // Reset values
    reset = 1'b1; enable = 1'b0; start_empty_n = 1'b0; start_dout = 1'b0;
    core_ready = 1'b0; core_done = 1'b0; done_full_n = 1'b1;
    step();
    step();
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_start_read", start_read, 0);
    chk("rst_ce", start_read_ce, 1);
    reset = 1'b0;

    // Test 1: single token, table-driven
    for (int i = 0; i < 7; i++) begin
      enable = vecs[i].en; start_empty_n = vecs[i].empty_n; start_dout = vecs[i].dout;
      core_ready = vecs[i].ready; core_done = vecs[i].done; done_full_n = vecs[i].full_n;
      #1;
      chk($sformatf("v%0d_start_read", i), start_read, vecs[i].e_sr);
      chk($sformatf("v%0d_core_start", i), core_start, vecs[i].e_cs);
      chk($sformatf("v%0d_done_write", i), done_write, vecs[i].e_dw);
      chk($sformatf("v%0d_continue", i), core_continue, vecs[i].e_cont);
      chk($sformatf("v%0d_idle", i), idle, vecs[i].e_idle);
      chk($sformatf("v%0d_state", i), dbg_state, vecs[i].e_state);
      if (vecs[i].e_dw) chk($sformatf("v%0d_done_din", i), done_din, vecs[i].e_din);
      chk($sformatf("v%0d_iter", i), iter_cnt, vecs[i].e_iter);
      step();
    end
    exp_iter = 1;

    // Test 2: five preloaded tokens, back to back
    for (int k = 0; k < 5; k++) drive_iter(1'(k & 1), 0, (k < 4));
    chk("t2_iter5", iter_cnt, 6);

    // Test 3: done FIFO full for 10 cycles
    drive_iter(1'b1, 10, 1'b0);

    // Test 4: enable low holds off the pop
    enable = 1'b0; start_empty_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t4_no_pop", start_read, 0);
      chk("t4_idle", idle, 1);
      step();
    end
    drive_iter(1'b0, 0, 1'b0);

    // Test 5: reset while the core is running
    enable = 1'b1; start_empty_n = 1'b1; start_dout = 1'b1;
    step();
    core_ready = 1'b1; start_empty_n = 1'b0;
    step();
    core_ready = 1'b0;
    #1;
    chk("t5_in_run", dbg_state, 2'd2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; enable = 1'b0;
    #1;
    chk("t5_idle", idle, 1);
    chk("t5_core_start", core_start, 0);
    chk("t5_iter", iter_cnt, 0);
    chk("t5_err", proto_err, 0);
    exp_iter = 0;
    drive_iter(1'b1, 0, 1'b0);

    // Test 6: 2-bit counter wraps; wide counter keeps counting
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_iter(1'b1, 0, 1'b1);
      chk($sformatf("t6_w2_iter%0d", k), b_iter_cnt, (k + 1) % 4);
    end
    chk("t6_err_clean", proto_err, 0);
    enable = 1'b0; start_empty_n = 1'b0; core_done = 1'b1;
    step();
    core_done = 1'b0;
    #1;
    chk("t6_err_set", proto_err, 1);
    chk("t6_err_set_w2", b_proto_err, 1);
    chk("t6_idle_kept", idle, 1);
    step();
    step();
    #1;
    chk("t6_err_sticky", proto_err, 1);

    // Done without ready during launch is flagged and ignored
    do_reset();
    enable = 1'b1; start_empty_n = 1'b1; start_dout = 1'b1;
    step();
    enable = 1'b0; start_empty_n = 1'b0; core_done = 1'b1;
    step();
    core_done = 1'b0;
    #1;
    chk("launch_err", proto_err, 1);
    chk("launch_held", core_start, 1);
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    #1;
    chk("launch_to_run", dbg_state, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
